program_loader: RTL
===================

Name: program_loader

Overview:
- Upstream feeder for the cpu instruction-memory initialization port.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives initialize / instruction_initialize_address / instruction_initialize_data with each word held stable for a programmable number of cycles.
- Holds the cpu in reset while loading, then releases initialize and the cpu reset together so the program starts at address 0.

Parameters:
- MAX_WORDS, 256: instruction memory capacity in words. Must be a power of 2.
- WRITE_HOLD, 2: cycles each address/data pair is held stable (minimum 1).
- CW, 9: width of word_count; equals clog2(MAX_WORDS)+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a (re)load from address 0.
- in_data  in  8  stream byte; first byte of a word is the MSB.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final byte of the program; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- initialize  out  1  to cpu initialize.
- instruction_initialize_address  out  32  byte address, multiple of 4.
- instruction_initialize_data  out  32  assembled word.
- cpu_rst  out  1  to cpu rst; active-high hold.
- done  out  1  high while the cpu is running the loaded program.
- word_count  out  CW  number of words written.
- partial  out  1  sticky: in_last arrived mid-word.
- overflow  out  1  sticky: MAX_WORDS reached without in_last.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - initialize=1, cpu_rst=1.
  - address=0, data=0, in_ready=0, done=0, word_count=0, partial=0, overflow=0.
  - Byte counter=0.
  - Reset asserted mid-load aborts the load immediately; nothing is retained.
- Byte acceptance: a byte is accepted only when in_valid=1 and in_ready=1 on a rising edge. in_ready is registered and is high only in COLLECT.
- IDLE:
  - initialize=1, cpu_rst=1.
  - On start, go to COLLECT. Clear address, word_count, flags and byte counter.
- COLLECT:
  - in_ready=1.
  - Each accepted byte: shift register word <= {word[23:0], in_data}; byte counter increments (mod 4).
  - On the 4th byte, or on any byte with in_last=1: go to WRITE the next cycle with in_ready=0.
  - Drive data=word, with zero-padding of the remaining low bytes if in_last arrived on byte 1-3, which also sets partial.
  - Record the last flag.
  - start is ignored in this state.
- WRITE:
  - Address and data are held stable for exactly WRITE_HOLD cycles; in_ready=0.
  - On exit: address += 4, word_count += 1, byte counter=0.
  - If last is set, go to RELEASE.
  - Else if word_count+1 == MAX_WORDS, set overflow and go to RELEASE.
  - Else return to COLLECT.
  - start is ignored in this state.
- RELEASE (1 cycle): initialize and cpu_rst both deassert on the same edge as entry to RUN; they never change on different edges.
- RUN:
  - done=1, initialize=0, cpu_rst=0, in_ready=0.
  - Bytes offered in RUN are not accepted.
  - On start: initialize=1, cpu_rst=1 and done=0 on the next edge; clear counters; go to COLLECT (reload).
- Arithmetic:
  - Address is 32-bit and increments by 4; it never wraps, because it is bounded by MAX_WORDS.
  - word_count saturates at MAX_WORDS.
- Simultaneous events:
  - in_last together with the 4th byte is a normal end; partial stays 0.
  - start together with reset: reset wins.
- Empty program: not possible. At least one byte with in_last is required to leave COLLECT; the loader waits indefinitely.

Test Plan:
- Reset then start, stream 00 02 08 20 (last on 20) -> address 0, data 32'h00020820 held for 2 cycles with initialize=1; then initialize=0 and cpu_rst=0 on the same edge; done=1; word_count=1.
- Stream 5 words, the first 00020820 then 20620001, 20620002, 20620003, 20620004 (last on final byte), with in_valid gaps -> addresses 0,4,8,12,16 with matching data; no byte lost or duplicated; word_count=5; in_ready low throughout each WRITE.
- Stream 20 62 with in_last on 62 -> data 32'h20620000 at address 0; partial=1; cpu released.
- MAX_WORDS=4, stream 5 words without last -> 4 writes (addresses 0-12); overflow=1; in_ready stays 0; RUN entered.
- Assert rst=0 during the second word's WRITE -> all outputs return to reset values asynchronously; a subsequent start reloads from address 0.
- From RUN, pulse start -> cpu_rst=1 and initialize=1 next edge, done=0; a new 1-word load completes normally.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words and drives the cpu
// instruction-memory initialization port, then releases the cpu to run from address 0.
module program_loader #(
  parameter int MAX_WORDS  = 256,
  parameter int WRITE_HOLD = 2,
  parameter int CW         = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic          initialize,
  output logic [31:0]   instruction_initialize_address,
  output logic [31:0]   instruction_initialize_data,
  output logic          cpu_rst,
  output logic          done,
  output logic [CW-1:0] word_count,
  output logic          partial,
  output logic          overflow
);

  localparam int HW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(WRITE_HOLD - 1);
  localparam logic [CW-1:0] WORDS_MAX = CW'(MAX_WORDS);
  localparam logic [CW-1:0] LAST_IDX  = CW'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t        state_q;
  logic [23:0]   word_q;
  logic [1:0]    byte_cnt_q;
  logic [HW-1:0] hold_q;
  logic          last_q;
  logic          in_ready_q;
  logic          initialize_q;
  logic          cpu_rst_q;
  logic          done_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [CW-1:0] word_count_q;
  logic          partial_q;
  logic          overflow_q;

  logic          accept_d;
  logic          end_of_word_d;
  logic [31:0]   word_d;
  logic [CW-1:0] word_count_d;

  assign accept_d      = in_valid & in_ready_q;
  assign end_of_word_d = (byte_cnt_q == 2'd3) | in_last;
  assign word_count_d  = (word_count_q == WORDS_MAX) ? word_count_q : word_count_q + CW'(1);

  // Left-align the bytes received so far; missing low bytes of a short final word read as zero.
  always_comb begin
    word_d = 32'h0;
    unique case (byte_cnt_q)
      2'd0:    word_d = {in_data, 24'h0};
      2'd1:    word_d = {word_q[7:0], in_data, 16'h0};
      2'd2:    word_d = {word_q[15:0], in_data, 8'h0};
      default: word_d = {word_q[23:0], in_data};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      word_q       <= 24'h0;
      byte_cnt_q   <= 2'd0;
      hold_q       <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      initialize_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      word_count_q <= '0;
      partial_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (start) begin
            state_q      <= S_COLLECT;
            in_ready_q   <= 1'b1;
            initialize_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            addr_q       <= 32'h0;
            word_count_q <= '0;
            partial_q    <= 1'b0;
            overflow_q   <= 1'b0;
            byte_cnt_q   <= 2'd0;
            last_q       <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (accept_d) begin
            word_q     <= {word_q[15:0], in_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (end_of_word_d) begin
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              data_q     <= word_d;
              last_q     <= in_last;
              hold_q     <= '0;
              if (in_last && (byte_cnt_q != 2'd3)) begin
                partial_q <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          if (hold_q == HOLD_LAST) begin
            addr_q       <= addr_q + 32'd4;
            word_count_q <= word_count_d;
            byte_cnt_q   <= 2'd0;
            if (last_q) begin
              state_q <= S_RELEASE;
            end else if (word_count_q == LAST_IDX) begin
              overflow_q <= 1'b1;
              state_q    <= S_RELEASE;
            end else begin
              state_q    <= S_COLLECT;
              in_ready_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_RELEASE: begin
          // initialize and cpu_rst drop on the same edge so the cpu starts cleanly at address 0.
          state_q      <= S_RUN;
          initialize_q <= 1'b0;
          cpu_rst_q    <= 1'b0;
          done_q       <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready                       = in_ready_q;
  assign initialize                     = initialize_q;
  assign instruction_initialize_address = addr_q;
  assign instruction_initialize_data    = data_q;
  assign cpu_rst                        = cpu_rst_q;
  assign done                           = done_q;
  assign word_count                     = word_count_q;
  assign partial                        = partial_q;
  assign overflow                       = overflow_q;

endmodule
